// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial memory controller between the IF/MEM stages and an 8-bit RAM
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_inst,
    output logic              if_done,
    input  logic              mem_load_enable,
    input  logic              mem_store_enable,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [2:0]        mem_funct3,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              mem_stall,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        last_q, last_d;      // index of the final byte (n-1)
    logic              fetch_q, fetch_d;
    logic [1:0]        cnt_q, cnt_d;        // index of the byte whose address is on ram_a
    logic [1:0]        cap_q, cap_d;        // index of the next byte to capture
    logic              din_ok_q, din_ok_d;  // ram_din this cycle carries byte cap_q
    logic [31:0]       buf_q, buf_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              wr_q, wr_d;
    logic [31:0]       if_inst_q, if_inst_d;
    logic              if_done_q, if_done_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              mem_done_q, mem_done_d;
    logic [31:0]       word;
    logic [1:0]        cap_n;

    function automatic logic [1:0] size_last(input logic [2:0] f3);
        logic [1:0] r;
        if (f3[1])      r = 2'd3;
        else if (f3[0]) r = 2'd1;
        else            r = 2'd0;
        return r;
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        logic [7:0] r;
        case (i)
            2'd0:    r = w[7:0];
            2'd1:    r = w[15:8];
            2'd2:    r = w[23:16];
            default: r = w[31:24];
        endcase
        return r;
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] i,
                                             input logic [7:0] b);
        logic [31:0] r;
        case (i)
            2'd0:    r = {w[31:8], b};
            2'd1:    r = {w[31:16], b, w[7:0]};
            2'd2:    r = {w[31:24], b, w[15:0]};
            default: r = {b, w[23:0]};
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [2:0] f3);
        logic [31:0] r;
        if (f3[1])      r = w;
        else if (f3[0]) r = f3[2] ? {16'h0000, w[15:0]} : {{16{w[15]}}, w[15:0]};
        else            r = f3[2] ? {24'h000000, w[7:0]} : {{24{w[7]}}, w[7:0]};
        return r;
    endfunction

    // Next-state and next-output logic; rdy=0 freezes everything except the read-data validity flag
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        f3_d        = f3_q;
        wdata_d     = wdata_q;
        last_d      = last_q;
        fetch_d     = fetch_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        din_ok_d    = din_ok_q;
        buf_d       = buf_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        wr_d        = wr_q;
        if_inst_d   = if_inst_q;
        if_done_d   = if_done_q;
        mem_rdata_d = mem_rdata_q;
        mem_done_d  = mem_done_q;
        word        = put_byte(buf_q, cap_q, ram_din);
        cap_n       = cap_q + {1'b0, din_ok_q};

        if (rdy) begin
            if_done_d  = 1'b0;
            mem_done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    wr_d     = 1'b0;
                    cnt_d    = 2'd0;
                    cap_d    = 2'd0;
                    din_ok_d = 1'b0;
                    buf_d    = 32'h0;
                    if (mem_store_enable) begin
                        state_d    = WRITE;
                        addr_d     = mem_addr;
                        f3_d       = mem_funct3;
                        wdata_d    = mem_wdata;
                        last_d     = size_last(mem_funct3);
                        fetch_d    = 1'b0;
                        ram_a_d    = mem_addr;
                        ram_dout_d = mem_wdata[7:0];
                        wr_d       = 1'b1;
                    end else if (mem_load_enable) begin
                        state_d = READ;
                        addr_d  = mem_addr;
                        f3_d    = mem_funct3;
                        last_d  = size_last(mem_funct3);
                        fetch_d = 1'b0;
                        ram_a_d = mem_addr;
                    end else if (if_req) begin
                        state_d = READ;
                        addr_d  = if_addr;
                        f3_d    = 3'b010;
                        last_d  = 2'd3;
                        fetch_d = 1'b1;
                        ram_a_d = if_addr;
                    end
                end
                WRITE: begin
                    if (cnt_q == last_q) begin
                        wr_d       = 1'b0;
                        state_d    = DONE;
                        mem_done_d = 1'b1;
                    end else begin
                        cnt_d      = cnt_q + 2'd1;
                        ram_a_d    = ram_a_q + ADDR_ONE;
                        ram_dout_d = byte_sel(wdata_q, cnt_q + 2'd1);
                    end
                end
                READ: begin
                    if (din_ok_q) begin
                        buf_d = word;
                        cap_d = cap_n;
                    end
                    if (din_ok_q && cap_q == last_q) begin
                        state_d  = DONE;
                        din_ok_d = 1'b0;
                        if (fetch_q) begin
                            if_inst_d = word;
                            if_done_d = 1'b1;
                        end else begin
                            mem_rdata_d = extend_load(word, f3_q);
                            mem_done_d  = 1'b1;
                        end
                    end else if (cnt_q == cap_n) begin
                        // Pipeline in step: next cycle's ram_din belongs to byte cap_n
                        din_ok_d = 1'b1;
                        if (cnt_q != last_q) begin
                            cnt_d   = cnt_q + 2'd1;
                            ram_a_d = ram_a_q + ADDR_ONE;
                        end
                    end else begin
                        // A stall let the address run ahead of the data; re-present the pending byte
                        din_ok_d = 1'b0;
                        cnt_d    = cap_n;
                        ram_a_d  = addr_q + {{(ADDR_W-2){1'b0}}, cap_n};
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else if (state_q == READ) begin
            // ram_a is held, so the RAM keeps returning the byte at ram_a
            din_ok_d = (cnt_q == cap_q);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            f3_q        <= 3'b000;
            wdata_q     <= 32'h0;
            last_q      <= 2'd0;
            fetch_q     <= 1'b0;
            cnt_q       <= 2'd0;
            cap_q       <= 2'd0;
            din_ok_q    <= 1'b0;
            buf_q       <= 32'h0;
            ram_a_q     <= '0;
            ram_dout_q  <= 8'h00;
            wr_q        <= 1'b0;
            if_inst_q   <= 32'h0;
            if_done_q   <= 1'b0;
            mem_rdata_q <= 32'h0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            f3_q        <= f3_d;
            wdata_q     <= wdata_d;
            last_q      <= last_d;
            fetch_q     <= fetch_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            din_ok_q    <= din_ok_d;
            buf_q       <= buf_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            wr_q        <= wr_d;
            if_inst_q   <= if_inst_d;
            if_done_q   <= if_done_d;
            mem_rdata_q <= mem_rdata_d;
            mem_done_q  <= mem_done_d;
        end
    end

    assign ram_a     = ram_a_q;
    assign ram_dout  = ram_dout_q;
    assign ram_wr    = wr_q & rdy;
    assign if_inst   = if_inst_q;
    assign mem_rdata = mem_rdata_q;
    assign if_done   = if_done_q & rdy;
    assign mem_done  = mem_done_q & rdy;
    assign mem_stall = (mem_load_enable | mem_store_enable | if_req) & ~(mem_done | if_done);

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_inst;
    logic        if_done;
    logic        mem_load_enable = 1'b0;
    logic        mem_store_enable = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [2:0]  mem_funct3 = 3'b000;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_stall;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    logic [7:0]  ram [4096];
    logic        poke_en = 1'b0;
    logic [11:0] poke_a = 12'h0;
    logic [7:0]  poke_d = 8'h0;

    int vectors = 0;
    int miscompares = 0;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst), .if_done(if_done),
        .mem_load_enable(mem_load_enable), .mem_store_enable(mem_store_enable),
        .mem_addr(mem_addr), .mem_funct3(mem_funct3), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    always #5 clk = ~clk;

    // Byte RAM with one-cycle read latency, aliased on the low 12 address bits
    always @(posedge clk) begin
        ram_din <= ram[ram_a[11:0]];
        if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
        if (poke_en) ram[poke_a] <= poke_d;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        poke_a  = a;
        poke_d  = d;
        poke_en = 1'b1;
        step();
        poke_en = 1'b0;
    endtask

    // Load of nbytes; ram_a checked per cycle, done expected in cycle nbytes+2
    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] exp, input int nbytes);
        int got;
        got = 0;
        mem_load_enable = 1'b1;
        mem_funct3      = f3;
        mem_addr        = a;
        for (int c = 1; c <= 20 && got == 0; c++) begin
            step();
            if (c <= nbytes) chk({tag, " ram_a"}, ram_a, a + c - 1);
            if (mem_done) got = c;
        end
        chk({tag, " done cycle"}, got, nbytes + 2);
        chk({tag, " data"}, mem_rdata, exp);
        mem_load_enable = 1'b0;
        step();
        chk({tag, " single pulse"}, {31'h0, mem_done}, 32'h0);
    endtask

    // Store of nbytes; each write cycle checked, done expected in cycle nbytes+1
    task automatic store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int nbytes);
        logic [31:0] sh;
        sh = wd;
        mem_store_enable = 1'b1;
        mem_funct3       = f3;
        mem_addr         = a;
        mem_wdata        = wd;
        for (int c = 1; c <= nbytes; c++) begin
            step();
            chk({tag, " wr"}, {31'h0, ram_wr}, 32'h1);
            chk({tag, " addr"}, ram_a, a + c - 1);
            chk({tag, " byte"}, {24'h0, ram_dout}, {24'h0, sh[7:0]});
            sh = sh >> 8;
        end
        step();
        chk({tag, " done"}, {31'h0, mem_done}, 32'h1);
        chk({tag, " wr idle"}, {31'h0, ram_wr}, 32'h0);
        mem_store_enable = 1'b0;
        step();
    endtask

    initial begin
        int got;
        int got2;
        int n_if;
        int n_mem;

        // Preload while reset is held
        poke(12'h100, 8'h13); poke(12'h101, 8'h05); poke(12'h102, 8'h00); poke(12'h103, 8'h00);
        poke(12'h020, 8'h80); poke(12'h021, 8'h7F);
        poke(12'h200, 8'h78); poke(12'h201, 8'h56); poke(12'h202, 8'h34); poke(12'h203, 8'h12);
        poke(12'hFFE, 8'h11); poke(12'hFFF, 8'h22); poke(12'h000, 8'h33); poke(12'h001, 8'h44);
        poke(12'h080, 8'h00);

        chk("rst if_inst", if_inst, 32'h0);
        chk("rst if_done", {31'h0, if_done}, 32'h0);
        chk("rst mem_rdata", mem_rdata, 32'h0);
        chk("rst mem_done", {31'h0, mem_done}, 32'h0);
        chk("rst ram_a", ram_a, 32'h0);
        chk("rst ram_dout", {24'h0, ram_dout}, 32'h0);
        chk("rst ram_wr", {31'h0, ram_wr}, 32'h0);
        chk("rst mem_stall", {31'h0, mem_stall}, 32'h0);
        rst = 1'b1;
        step();

        // Instruction fetch at 0x100
        if_req  = 1'b1;
        if_addr = 32'h100;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c <= 4) chk("fetch ram_a", ram_a, 32'h100 + c - 1);
            if (c == 1) chk("fetch stall", {31'h0, mem_stall}, 32'h1);
            if (c == 5) chk("fetch early done", {31'h0, if_done}, 32'h0);
        end
        chk("fetch done", {31'h0, if_done}, 32'h1);
        chk("fetch inst", if_inst, 32'h00000513);
        chk("fetch stall released", {31'h0, mem_stall}, 32'h0);
        if_req = 1'b0;
        step();
        chk("fetch pulse ends", {31'h0, if_done}, 32'h0);
        chk("fetch inst held", if_inst, 32'h00000513);

        // Byte and halfword loads with both extensions
        load("LB", 3'b000, 32'h20, 32'hFFFFFF80, 1);
        load("LBU", 3'b100, 32'h20, 32'h00000080, 1);
        load("LH", 3'b001, 32'h20, 32'h00007F80, 2);

        // Word store, read back, byte store into the middle, read back
        store("SW", 3'b010, 32'h40, 32'hDEADBEEF, 4);
        load("LW40", 3'b010, 32'h40, 32'hDEADBEEF, 4);
        store("SB", 3'b000, 32'h41, 32'h0000005A, 1);
        load("LW40b", 3'b010, 32'h40, 32'hDEAD5AEF, 4);

        // Simultaneous load and fetch: load first, fetch after the DONE/IDLE gap
        if_req          = 1'b1;
        if_addr         = 32'h100;
        mem_load_enable = 1'b1;
        mem_funct3      = 3'b010;
        mem_addr        = 32'h200;
        got   = 0;
        got2  = 0;
        n_if  = 0;
        n_mem = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 1) chk("arb first addr", ram_a, 32'h200);
            if (mem_done) begin
                n_mem++;
                got = c;
                chk("arb load data", mem_rdata, 32'h12345678);
                mem_load_enable = 1'b0;
            end
            if (if_done) begin
                n_if++;
                got2 = c;
                chk("arb fetch inst", if_inst, 32'h00000513);
                if_req = 1'b0;
            end
        end
        chk("arb load cycle", got, 6);
        chk("arb fetch cycle", got2, 13);
        chk("arb if_done count", n_if, 1);
        chk("arb mem_done count", n_mem, 1);

        // rdy low for 3 cycles while the last byte of an LW is pending
        mem_load_enable = 1'b1;
        mem_funct3      = 3'b010;
        mem_addr        = 32'h200;
        got = 0;
        for (int c = 1; c <= 20 && got == 0; c++) begin
            step();
            if (c == 5) rdy = 1'b0;
            if (c == 8) rdy = 1'b1;
            if (c == 6) begin
                chk("stall ram_a held", ram_a, 32'h203);
                chk("stall ram_wr", {31'h0, ram_wr}, 32'h0);
            end
            if (mem_done) got = c;
        end
        chk("stall done cycle", got, 9);
        chk("stall data", mem_rdata, 32'h12345678);
        mem_load_enable = 1'b0;
        step();

        // Reset in the middle of a word store
        mem_store_enable = 1'b1;
        mem_funct3       = 3'b010;
        mem_addr         = 32'h80;
        mem_wdata        = 32'hCAFEF00D;
        step();
        step();
        chk("rstmid wr before", {31'h0, ram_wr}, 32'h1);
        rst = 1'b0;
        #1;
        chk("rstmid ram_wr", {31'h0, ram_wr}, 32'h0);
        chk("rstmid ram_a", ram_a, 32'h0);
        chk("rstmid ram_dout", {24'h0, ram_dout}, 32'h0);
        chk("rstmid mem_rdata", mem_rdata, 32'h0);
        chk("rstmid if_inst", if_inst, 32'h0);
        mem_store_enable = 1'b0;
        n_mem = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (mem_done) n_mem++;
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (mem_done) n_mem++;
        end
        chk("rstmid no done", n_mem, 0);
        load("partial byte", 3'b000, 32'h80, 32'h0000000D, 1);

        // Address wrap across the top of the space
        load("wrap LW", 3'b010, 32'hFFFFFFFE, 32'h44332211, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
